// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states, default widths.
package muldiv_unit_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_CNT_W = 5;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: one shift-add (multiply) or restoring-subtract (divide) step per cycle.
// acc holds {partial_product_hi, multiplier} or {remainder, dividend/quotient}.
module muldiv_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 step,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 last_c
);

  logic [WIDTH-1:0]   m;
  logic               div_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] acc_n;

  // Next accumulator value for the current mode
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, m};
    if (div_q) begin
      acc_n = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                          : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = {sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      m     <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      m     <= div ? b : a;
      div_q <= div;
      acc   <= div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      cnt   <= '0;
    end else if (step) begin
      acc <= acc_n;
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last_c = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO registers: FSM, sign handling and MTHI/MTLO path.
// Define MULDIV_FAST_MULT_EN for single-cycle combinational MULT/MULTU.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned CNT_W = MD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state, state_n;
  logic [WIDTH-1:0]   hi_n, lo_n;
  logic               done_n;
  logic               neg_q, neg_n;
  logic               rneg_q, rneg_n;
  logic               div_q, div_n;
  logic               div0_q, div0_n;
  logic [WIDTH-1:0]   a_q, a_n;

  logic               load, step, last_c;
  logic [2*WIDTH-1:0] acc;
  logic               sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  // Operand magnitudes and signs for the signed ops
  assign sgn_op = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg  = sgn_op & opa[WIDTH-1];
  assign b_neg  = sgn_op & opb[WIDTH-1];
  assign a_mag  = a_neg ? -opa : opa;
  assign b_mag  = b_neg ? -opb : opb;

  // Sign-corrected results from the finished iteration
  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = sgn_op
    ? ({{WIDTH{opa[WIDTH-1]}}, opa} * {{WIDTH{opb[WIDTH-1]}}, opb})
    : ({{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb});
`endif

  muldiv_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .div    (op[1]),
    .a      (a_mag),
    .b      (b_mag),
    .step   (step),
    .acc    (acc),
    .last_c (last_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      div_q  <= 1'b0;
      div0_q <= 1'b0;
      a_q    <= '0;
    end else begin
      state  <= state_n;
      hi     <= hi_n;
      lo     <= lo_n;
      done   <= done_n;
      busy   <= (state_n != ST_IDLE);
      neg_q  <= neg_n;
      rneg_q <= rneg_n;
      div_q  <= div_n;
      div0_q <= div0_n;
      a_q    <= a_n;
    end
  end

  always_comb begin
    state_n = state;
    hi_n    = hi;
    lo_n    = lo;
    done_n  = 1'b0;
    neg_n   = neg_q;
    rneg_n  = rneg_q;
    div_n   = div_q;
    div0_n  = div0_q;
    a_n     = a_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
`ifdef MULDIV_FAST_MULT_EN
              if (!op[1]) begin
                {hi_n, lo_n} = fast_prod;
                done_n       = 1'b1;
              end else
`endif
              begin
                load    = 1'b1;
                state_n = ST_RUN;
                neg_n   = a_neg ^ b_neg;
                rneg_n  = a_neg;
                div_n   = op[1];
                div0_n  = (opb == '0);
                a_n     = opa;
              end
            end
            MD_MTHI: hi_n = opa;
            MD_MTLO: lo_n = opa;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_c) state_n = ST_FIX;
      end
      ST_FIX: begin
        // Divide by zero reports all-ones quotient and the raw dividend
        if (div_q && div0_q) begin
          hi_n = a_q;
          lo_n = '1;
        end else if (div_q) begin
          hi_n = rem;
          lo_n = quo;
        end else begin
          {hi_n, lo_n} = prod;
        end
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
